// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants and write-back types for the write-port arbiter.
// Imported by the arbiter top and its result FIFO.
package regfile_wb_arbiter_pkg;

    localparam int RF_ADDR_W  = 5;
    localparam int RF_DATA_W  = 32;
    localparam int RF_NREGS   = 32;
    localparam int WB_ENTRY_W = RF_ADDR_W + RF_DATA_W;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_PIPE = 2'd1,
        GRANT_FIFO = 2'd2
    } grant_e;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] wa;
        logic [RF_DATA_W-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Synchronous FIFO for buffered long-latency {wa,wd} results.
// Occupancy is tracked by a counter, so full/empty never rely on pointer equality.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push && pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read once counted as valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (cnt_q == CNT_W'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with buffered long-latency
// results, tracks per-register pending results, and forces a pipeline stall on FIFO starvation.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          pipe_we,
    input  logic [4:0]                    pipe_wa,
    input  logic [31:0]                   pipe_wd,
    output logic                          pipe_stall,
    input  logic                          iss_en,
    input  logic [4:0]                    iss_wa,
    input  logic                          ll_valid,
    output logic                          ll_ready,
    input  logic [4:0]                    ll_wa,
    input  logic [31:0]                   ll_wd,
    input  logic [4:0]                    chk_ra1,
    output logic                          chk_busy1,
    input  logic [4:0]                    chk_ra2,
    output logic                          chk_busy2,
    output logic                          Wen,
    output logic [4:0]                    Wa,
    output logic [31:0]                   Wd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int ST_W = $clog2(STARVE_MAX) + 1;

    logic                 wen_q, wen_d;
    logic [RF_ADDR_W-1:0] wa_q, wa_d;
    logic [RF_DATA_W-1:0] wd_q, wd_d;
    logic                 pipe_stall_q, pipe_stall_d;
    logic [RF_NREGS-1:0]  pending_q, pending_d;
    logic [ST_W-1:0]      starve_q, starve_d;

    grant_e               grant;
    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [WB_ENTRY_W-1:0] fifo_dout;
    wb_entry_t            head;

    // ll_valid/ll_ready: an entry transfers on a rising edge where both are high;
    // ll_wa/ll_wd must be stable in that cycle and ll_ready depends only on occupancy.
    assign ll_ready  = !fifo_full;
    assign fifo_push = ll_valid && ll_ready;
    assign fifo_pop  = (grant == GRANT_FIFO);
    assign head      = wb_entry_t'(fifo_dout);

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (WB_ENTRY_W)
    ) u_wb_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   ({ll_wa, ll_wd}),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    always_comb begin
        grant = GRANT_NONE;
        if (pipe_we && !pipe_stall_q) grant = GRANT_PIPE;
        else if (!fifo_empty)         grant = GRANT_FIFO;

        wen_d = 1'b0;
        wa_d  = wa_q;
        wd_d  = wd_q;
        case (grant)
            GRANT_PIPE: begin
                wen_d = (pipe_wa != '0);
                wa_d  = pipe_wa;
                wd_d  = pipe_wd;
            end
            GRANT_FIFO: begin
                wen_d = (head.wa != '0);
                wa_d  = head.wa;
                wd_d  = head.wd;
            end
            default: ;
        endcase

        // Clear before set so a same-register issue in the pop cycle stays pending.
        pending_d = pending_q;
        if (fifo_pop) pending_d[head.wa] = 1'b0;
        if (iss_en)   pending_d[iss_wa]  = 1'b1;
        pending_d[0] = 1'b0;

        starve_d = starve_q;
        if (fifo_empty || fifo_pop)              starve_d = '0;
        else if (starve_q != ST_W'(STARVE_MAX - 1)) starve_d = starve_q + ST_W'(1);

        pipe_stall_d = (starve_q == ST_W'(STARVE_MAX - 1)) && !fifo_empty
                       && !fifo_pop && !pipe_stall_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wen_q        <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            pipe_stall_q <= 1'b0;
            pending_q    <= '0;
            starve_q     <= '0;
        end else begin
            wen_q        <= wen_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            pipe_stall_q <= pipe_stall_d;
            pending_q    <= pending_d;
            starve_q     <= starve_d;
        end
    end

    assign Wen        = wen_q;
    assign Wa         = wa_q;
    assign Wd         = wd_q;
    assign pipe_stall = pipe_stall_q;
    assign chk_busy1  = pending_q[chk_ra1];
    assign chk_busy2  = pending_q[chk_ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a random mix,
// with a write-port scoreboard fed by a small transaction model of the arbiter.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk, rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_wa;
    logic [31:0] pipe_wd;
    logic        pipe_stall;
    logic        iss_en;
    logic [4:0]  iss_wa;
    logic        ll_valid, ll_ready;
    logic [4:0]  ll_wa;
    logic [31:0] ll_wd;
    logic [4:0]  chk_ra1, chk_ra2;
    logic        chk_busy1, chk_busy2;
    logic        Wen;
    logic [4:0]  Wa;
    logic [31:0] Wd;
    logic [2:0]  fifo_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [37:0] exp_q[$];   // {wen, wa, wd} expected one cycle after each step
    logic [36:0] mq[$];      // model FIFO of {wa, wd}
    logic [31:0] pend_m;     // model pending bits

    regfile_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
        .iss_en(iss_en), .iss_wa(iss_wa),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_wa(ll_wa), .ll_wd(ll_wd),
        .chk_ra1(chk_ra1), .chk_busy1(chk_busy1), .chk_ra2(chk_ra2), .chk_busy2(chk_busy2),
        .Wen(Wen), .Wa(Wa), .Wd(Wd), .fifo_cnt(fifo_cnt)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic set_idle();
        pipe_we  = 1'b0; pipe_wa = '0; pipe_wd = '0;
        iss_en   = 1'b0; iss_wa  = '0;
        ll_valid = 1'b0; ll_wa   = '0; ll_wd   = '0;
    endtask

    // One clock with the currently driven inputs; the model predicts the write port.
    task automatic step();
        logic [37:0] e;
        logic [36:0] h;
        bit can_push;
        can_push = (mq.size() < DEPTH);
        n_cmp++;
        if (ll_ready !== can_push) begin
            n_err++;
            $display("FAIL ll_ready: got %b exp %b", ll_ready, can_push);
        end
        e = '0;
        if (pipe_we) begin
            e = {pipe_wa != 5'd0, pipe_wa, pipe_wd};
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            e = {h[36:32] != 5'd0, h};
            pend_m[h[36:32]] = 1'b0;
        end
        if (iss_en) pend_m[iss_wa] = 1'b1;
        pend_m[0] = 1'b0;
        if (ll_valid && can_push) mq.push_back({ll_wa, ll_wd});
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        n_cmp++;
        if (Wen !== e[37] || (e[37] && {Wa, Wd} !== e[36:0])) begin
            n_err++;
            $display("FAIL wport: got wen=%b wa=%0d wd=%h exp wen=%b wa=%0d wd=%h",
                     Wen, Wa, Wd, e[37], e[36:32], e[31:0]);
        end
        n_cmp++;
        if (fifo_cnt !== 3'(mq.size())) begin
            n_err++;
            $display("FAIL fifo_cnt: got %0d exp %0d", fifo_cnt, mq.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        chk_ra1 = 5'd1; chk_ra2 = 5'd31;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (Wen !== 1'b0 || Wa !== 5'd0 || Wd !== 32'd0 || pipe_stall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_out: got wen=%b wa=%0d wd=%h stall=%b exp all 0", Wen, Wa, Wd, pipe_stall);
        end
        n_cmp++;
        if (fifo_cnt !== 3'd0 || ll_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_fifo: got cnt=%0d rdy=%b exp cnt=0 rdy=1", fifo_cnt, ll_ready);
        end
        n_cmp++;
        if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_busy: got %b%b exp 00", chk_busy1, chk_busy2);
        end
        pend_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pipe_write();
        set_idle();
        pipe_we = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'h1234;
        chk_ra1 = 5'd5;
        step();
        n_cmp++;
        if (Wen !== 1'b1 || Wa !== 5'd5 || Wd !== 32'h1234) begin
            n_err++;
            $display("FAIL pipe_write: got %b/%0d/%h exp 1/5/1234", Wen, Wa, Wd);
        end
        n_cmp++;
        if (chk_busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL pipe_pending: got %b exp 0", chk_busy1);
        end
    endtask

    task automatic test_ll_write();
        set_idle();
        iss_en = 1'b1; iss_wa = 5'd9;
        step();
        set_idle();
        chk_ra1 = 5'd9;
        #1;
        n_cmp++;
        if (chk_busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL ll_busy_issue: got %b exp 1", chk_busy1);
        end
        ll_valid = 1'b1; ll_wa = 5'd9; ll_wd = 32'hCAFE;
        step();
        set_idle();
        n_cmp++;
        if (chk_busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL ll_busy_queued: got %b exp 1", chk_busy1);
        end
        step();
        n_cmp++;
        if (Wen !== 1'b1 || Wa !== 5'd9 || Wd !== 32'hCAFE || chk_busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL ll_pop: got %b/%0d/%h busy=%b exp 1/9/cafe busy=0", Wen, Wa, Wd, chk_busy1);
        end
        step();
    endtask

    task automatic test_starve();
        int waits;
        set_idle();
        waits = 0;
        for (int i = 0; i < DEPTH; i++) begin
            pipe_we = 1'b1; pipe_wa = 5'd1; pipe_wd = 32'h100 + 32'(i);
            ll_valid = 1'b1; ll_wa = 5'(20 + i); ll_wd = 32'hA000 + 32'(i);
            step();
            waits++;
        end
        ll_valid = 1'b0;
        n_cmp++;
        if (ll_ready !== 1'b0 || fifo_cnt !== 3'd4) begin
            n_err++;
            $display("FAIL starve_full: got rdy=%b cnt=%0d exp rdy=0 cnt=4", ll_ready, fifo_cnt);
        end
        while (!pipe_stall && waits < 40) begin
            pipe_we = 1'b1; pipe_wd = 32'h200 + 32'(waits);
            step();
            waits++;
        end
        n_cmp++;
        if (waits != 9) begin
            n_err++;
            $display("FAIL starve_wait: got %0d cycles to stall exp 9", waits);
        end
        set_idle();
        step();
        n_cmp++;
        if (pipe_stall !== 1'b0 || Wen !== 1'b1 || Wa !== 5'd20 || fifo_cnt !== 3'd3) begin
            n_err++;
            $display("FAIL starve_grant: got stall=%b wen=%b wa=%0d cnt=%0d exp 0/1/20/3",
                     pipe_stall, Wen, Wa, fifo_cnt);
        end
        repeat (3) step();
    endtask

    task automatic test_set_clear_same();
        set_idle();
        ll_valid = 1'b1; ll_wa = 5'd7; ll_wd = 32'h77;
        step();
        set_idle();
        iss_en = 1'b1; iss_wa = 5'd7;
        step();
        set_idle();
        chk_ra1 = 5'd7;
        #1;
        n_cmp++;
        if (chk_busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL set_wins: got %b exp 1", chk_busy1);
        end
        ll_valid = 1'b1; ll_wa = 5'd7; ll_wd = 32'h78;
        step();
        set_idle();
        step();
        n_cmp++;
        if (chk_busy1 !== 1'b0) begin
            n_err++;
            $display("FAIL clear_later: got %b exp 0", chk_busy1);
        end
    endtask

    task automatic test_reg0();
        set_idle();
        pipe_we = 1'b1; pipe_wa = 5'd0; pipe_wd = 32'hFFFF;
        step();
        set_idle();
        ll_valid = 1'b1; ll_wa = 5'd0; ll_wd = 32'hBEEF;
        step();
        set_idle();
        iss_en = 1'b1; iss_wa = 5'd0;
        step();
        set_idle();
        chk_ra2 = 5'd0;
        #1;
        n_cmp++;
        if (Wen !== 1'b0 || fifo_cnt !== 3'd0 || chk_busy2 !== 1'b0) begin
            n_err++;
            $display("FAIL reg0: got wen=%b cnt=%0d busy=%b exp 0/0/0", Wen, fifo_cnt, chk_busy2);
        end
    endtask

    task automatic test_reset_mid();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            pipe_we = 1'b1; pipe_wa = 5'd3; pipe_wd = 32'h300 + 32'(i);
            ll_valid = 1'b1; ll_wa = 5'(12 + i); ll_wd = 32'hB00 + 32'(i);
            iss_en = 1'b1; iss_wa = 5'(12 + i);
            step();
        end
        set_idle();
        chk_ra1 = 5'd12; chk_ra2 = 5'd14;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (Wen !== 1'b0 || Wa !== 5'd0 || Wd !== 32'd0 || fifo_cnt !== 3'd0) begin
            n_err++;
            $display("FAIL mid_reset: got %b/%0d/%h cnt=%0d exp all 0", Wen, Wa, Wd, fifo_cnt);
        end
        n_cmp++;
        if (chk_busy1 !== 1'b0 || chk_busy2 !== 1'b0 || ll_ready !== 1'b1) begin
            n_err++;
            $display("FAIL mid_reset_sb: got busy=%b%b rdy=%b exp 00/1", chk_busy1, chk_busy2, ll_ready);
        end
        mq.delete();
        exp_q.delete();
        pend_m = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            set_idle();
            pipe_we  = pipe_stall ? 1'b0 : ($urandom_range(0, 2) == 0);
            pipe_wa  = 5'($urandom_range(0, 31));
            pipe_wd  = $urandom;
            ll_valid = ($urandom_range(0, 1) == 1);
            ll_wa    = 5'($urandom_range(0, 31));
            ll_wd    = $urandom;
            iss_en   = ($urandom_range(0, 3) == 0);
            iss_wa   = 5'($urandom_range(0, 31));
            chk_ra1  = 5'($urandom_range(0, 31));
            chk_ra2  = 5'($urandom_range(0, 31));
            #1;
            n_cmp++;
            if (chk_busy1 !== pend_m[chk_ra1] || chk_busy2 !== pend_m[chk_ra2]) begin
                n_err++;
                $display("FAIL rnd_busy: got %b%b exp %b%b (ra %0d,%0d)",
                         chk_busy1, chk_busy2, pend_m[chk_ra1], pend_m[chk_ra2], chk_ra1, chk_ra2);
            end
            step();
        end
        set_idle();
        repeat (DEPTH + 2) step();
    endtask

    initial begin
        test_reset();
        test_pipe_write();
        test_ll_write();
        test_starve();
        test_set_clear_same();
        test_reg0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
